// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - OTTER opcode/forward-select types and operand-usage decode helpers
package otter_pipe_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011,
    SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [1:0] {
    REGF = 2'b00,
    FEX  = 2'b01,
    FMEM = 2'b10,
    FWB  = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  function automatic logic writes_rd(input logic [31:0] ir, input logic vld);
    logic [6:0] op;
    op = ir[6:0];
    return vld && (op != BRANCH) && (op != STORE) && (ir[11:7] != 5'd0);
  endfunction

  // Opcode 0 is the bubble encoding and never reads a register.
  function automatic logic uses_rs1(input logic [31:0] ir);
    logic [6:0] op;
    op = ir[6:0];
    return (op != 7'd0) && (op != LUI) && (op != AUIPC) && (op != JAL);
  endfunction

  function automatic logic uses_rs2(input logic [31:0] ir);
    logic [6:0] op;
    op = ir[6:0];
    return (op == BRANCH) || (op == STORE) || (op == OP);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode/producer inputs and pipeline control outputs of the hazard unit
interface pipe_hazard_ctrl_if #(
  parameter int NUM_PROD = 3
);
  logic [31:0]            dec_ir;
  logic [32*NUM_PROD-1:0] prod_ir;
  logic [NUM_PROD-1:0]    prod_vld;
  logic                   flush;
  logic                   pc_write;
  logic                   dec_en;
  logic                   ex_clear;
  logic [1:0]             fwd_a_sel;
  logic [1:0]             fwd_b_sel;
  logic                   stall;

  modport master (
    output dec_ir, prod_ir, prod_vld, flush,
    input  pc_write, dec_en, ex_clear, fwd_a_sel, fwd_b_sel, stall
  );

  modport slave (
    input  dec_ir, prod_ir, prod_vld, flush,
    output pc_write, dec_en, ex_clear, fwd_a_sel, fwd_b_sel, stall
  );
endinterface

// File: rtl/pipe_hazard_ctrl_match.sv
// rtl/pipe_hazard_ctrl_match.sv - one producer stage versus the DEC instruction's source registers
module hazard_match
  import otter_pipe_pkg::*;
(
  input  logic [31:0] dec_ir,
  input  logic [31:0] prod_ir,
  input  logic        prod_vld,
  output logic        match_a,
  output logic        match_b,
  output logic        is_load
);
  logic wr;

  assign wr      = writes_rd(prod_ir, prod_vld);
  assign match_a = wr && uses_rs1(dec_ir) && (prod_ir[11:7] == dec_ir[19:15]);
  assign match_b = wr && uses_rs2(dec_ir) && (prod_ir[11:7] == dec_ir[24:20]);
  assign is_load = (prod_ir[6:0] == LOAD);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - OTTER data-hazard controller: forwarding selects or counted stall
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module pipe_hazard_ctrl
  import otter_pipe_pkg::*;
#(
  parameter int NUM_PROD = 3,
  parameter int FWD_EN   = 1,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef HAZARD_STATS_EN
  output logic [STAT_W-1:0] stall_cycles,
`endif
  pipe_hazard_ctrl_if.slave hz
);
  logic [2:0] m_a, m_b, ld;
  logic [1:0] need, cnt, cnt_n;
  logic       load_use, stall_c;
  fwd_sel_t   sel_a, sel_b, fa, fb;
  hz_state_t  state, state_n;

  // Stages beyond NUM_PROD are tied off so they can never match.
  for (genvar i = 0; i < 3; i++) begin : g_prod
    if (i < NUM_PROD) begin : g_on
      hazard_match u_match (
        .dec_ir  (hz.dec_ir),
        .prod_ir (hz.prod_ir[32*i +: 32]),
        .prod_vld(hz.prod_vld[i]),
        .match_a (m_a[i]),
        .match_b (m_b[i]),
        .is_load (ld[i])
      );
    end else begin : g_off
      assign m_a[i] = 1'b0;
      assign m_b[i] = 1'b0;
      assign ld[i]  = 1'b0;
    end
  end

  always_comb begin
    sel_a    = REGF;
    sel_b    = REGF;
    need     = 2'd0;
    load_use = 1'b0;
    if (FWD_EN != 0) begin
      // A load in EX has no data yet, so its forward is dropped and a single stall waits it into MEM.
      load_use = ld[0] && (m_a[0] || m_b[0]);
      if (m_a[0] && !ld[0]) sel_a = FEX;
      else if (m_a[1])      sel_a = FMEM;
      else if (m_a[2])      sel_a = FWB;
      if (m_b[0] && !ld[0]) sel_b = FEX;
      else if (m_b[1])      sel_b = FMEM;
      else if (m_b[2])      sel_b = FWB;
      need = load_use ? 2'd1 : 2'd0;
    end else begin
      for (int i = NUM_PROD - 1; i >= 0; i--) begin
        if (m_a[i] || m_b[i]) need = 2'(NUM_PROD - i);
      end
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    stall_c       = 1'b0;
    fa            = REGF;
    fb            = REGF;
    hz.pc_write   = 1'b1;
    hz.dec_en     = 1'b1;
    hz.ex_clear   = 1'b0;
    if (rst) begin
      state_n = IDLE;
      cnt_n   = 2'd0;
    end else if (flush_active()) begin
      hz.ex_clear = 1'b1;
      fa          = sel_a;
      fb          = sel_b;
      state_n     = IDLE;
      cnt_n       = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          fa = sel_a;
          fb = sel_b;
          if (need != 2'd0) begin
            stall_c = 1'b1;
            if (need > 2'd1) begin
              cnt_n   = need - 2'd1;
              state_n = STALL;
            end
          end
        end
        STALL: begin
          stall_c = 1'b1;
          cnt_n   = cnt - 2'd1;
          if (cnt == 2'd1) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
      if (stall_c) begin
        hz.pc_write = 1'b0;
        hz.dec_en   = 1'b0;
        hz.ex_clear = 1'b1;
      end
    end
  end

  function automatic logic flush_active();
    return hz.flush;
  endfunction

  assign hz.stall     = stall_c;
  assign hz.fwd_a_sel = fa;
  assign hz.fwd_b_sel = fb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                                  stall_cycles <= '0;
    else if (stall_c && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
  end
`else
  logic [STAT_W-1:0] unused_stat_w;
  assign unused_stat_w = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed checks of pipe_hazard_ctrl in stall-only and forwarding builds
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dec_ir;
  logic [95:0] prod_ir;
  logic [2:0]  prod_vld;
  logic        flush;
  int          n_chk = 0;
  int          n_pass = 0;
`ifdef HAZARD_STATS_EN
  logic [15:0] sc0, sc1;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NUM_PROD(3)) if0 ();
  pipe_hazard_ctrl_if #(.NUM_PROD(3)) if1 ();

  assign if0.dec_ir = dec_ir;   assign if1.dec_ir = dec_ir;
  assign if0.prod_ir = prod_ir; assign if1.prod_ir = prod_ir;
  assign if0.prod_vld = prod_vld; assign if1.prod_vld = prod_vld;
  assign if0.flush = flush;     assign if1.flush = flush;

  pipe_hazard_ctrl #(.NUM_PROD(3), .FWD_EN(0), .STAT_W(16)) u0 (
    .clk(clk), .rst(rst),
`ifdef HAZARD_STATS_EN
    .stall_cycles(sc0),
`endif
    .hz(if0.slave)
  );

  pipe_hazard_ctrl #(.NUM_PROD(3), .FWD_EN(1), .STAT_W(16)) u1 (
    .clk(clk), .rst(rst),
`ifdef HAZARD_STATS_EN
    .stall_cycles(sc1),
`endif
    .hz(if1.slave)
  );

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1, rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prod(input int idx, input logic [31:0] ir, input logic vld);
    prod_ir[32*idx +: 32] = ir;
    prod_vld[idx]         = vld;
  endtask

  task automatic do_reset();
    dec_ir = '0; prod_ir = '0; prod_vld = '0; flush = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] addi_x5, add_x6, add_x7, sub_x8, lw_x9, sw_x9, addi_x0, add_x6_x0;

  initial begin
    addi_x5   = enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011);
    add_x6    = enc_r(7'h00, 5'd5, 5'd5, 5'd6);
    add_x7    = enc_r(7'h00, 5'd2, 5'd1, 5'd7);
    sub_x8    = enc_r(7'h20, 5'd3, 5'd7, 5'd8);
    lw_x9     = enc_i(12'd0, 5'd1, 3'b010, 5'd9, 7'b0000011);
    sw_x9     = enc_s(12'd4, 5'd9, 5'd2);
    addi_x0   = enc_i(12'd1, 5'd5, 3'b000, 5'd0, 7'b0010011);
    add_x6_x0 = enc_r(7'h00, 5'd0, 5'd0, 5'd6);

    // Reset holds outputs at idle values even with a live hazard present.
    rst = 1'b1; flush = 1'b0; prod_ir = '0; prod_vld = '0;
    dec_ir = add_x6; set_prod(0, addi_x5, 1'b1);
    @(negedge clk);
    chk("rst_stall", {31'd0, if0.stall}, 32'd0);
    chk("rst_pc_write", {31'd0, if0.pc_write}, 32'd1);
    chk("rst_ex_clear", {31'd0, if0.ex_clear}, 32'd0);
    chk("rst_fwd_a", {30'd0, if1.fwd_a_sel}, 32'd0);
    tick();
    rst = 1'b0;

    // Stall-only: EX match costs three stall cycles; forwarding build tracks the producer.
    @(negedge clk);
    chk("s1_c1_stall", {31'd0, if0.stall}, 32'd1);
    chk("s1_c1_pc_write", {31'd0, if0.pc_write}, 32'd0);
    chk("s1_c1_dec_en", {31'd0, if0.dec_en}, 32'd0);
    chk("s1_c1_ex_clear", {31'd0, if0.ex_clear}, 32'd1);
    chk("s1_c1_fwd_a_ex", {30'd0, if1.fwd_a_sel}, 32'd1);
    chk("s1_c1_fwd_b_ex", {30'd0, if1.fwd_b_sel}, 32'd1);
    chk("s1_c1_fwd_nostall", {31'd0, if1.stall}, 32'd0);
    tick();
    set_prod(0, 32'd0, 1'b0); set_prod(1, addi_x5, 1'b1);
    @(negedge clk);
    chk("s1_c2_stall", {31'd0, if0.stall}, 32'd1);
    chk("s1_c2_fwd_a_mem", {30'd0, if1.fwd_a_sel}, 32'd2);
    tick();
    set_prod(1, 32'd0, 1'b0); set_prod(2, addi_x5, 1'b1);
    @(negedge clk);
    chk("s1_c3_stall", {31'd0, if0.stall}, 32'd1);
    chk("s1_c3_fwd_b_wb", {30'd0, if1.fwd_b_sel}, 32'd3);
    tick();
    set_prod(2, 32'd0, 1'b0);
    @(negedge clk);
    chk("s1_release_stall", {31'd0, if0.stall}, 32'd0);
    chk("s1_release_pc_write", {31'd0, if0.pc_write}, 32'd1);
`ifdef HAZARD_STATS_EN
    chk("s1_stall_cycles", {16'd0, sc0}, 32'd3);
`endif

    // Forwarding from EX, youngest-wins priority, and fallback to MEM.
    do_reset();
    dec_ir = sub_x8; set_prod(0, add_x7, 1'b1);
    @(negedge clk);
    chk("f_ex_a", {30'd0, if1.fwd_a_sel}, 32'd1);
    chk("f_ex_b", {30'd0, if1.fwd_b_sel}, 32'd0);
    chk("f_ex_stall", {31'd0, if1.stall}, 32'd0);
    tick();
    set_prod(1, add_x7, 1'b1);
    @(negedge clk);
    chk("f_youngest_a", {30'd0, if1.fwd_a_sel}, 32'd1);
    tick();
    prod_vld[0] = 1'b0;
    @(negedge clk);
    chk("f_mem_a", {30'd0, if1.fwd_a_sel}, 32'd2);

    // Load-use: one stall with EX forward dropped, then MEM forward.
    do_reset();
    dec_ir = sw_x9; set_prod(0, lw_x9, 1'b1);
    @(negedge clk);
    chk("lu_stall", {31'd0, if1.stall}, 32'd1);
    chk("lu_pc_write", {31'd0, if1.pc_write}, 32'd0);
    chk("lu_ex_clear", {31'd0, if1.ex_clear}, 32'd1);
    chk("lu_fwd_b_supp", {30'd0, if1.fwd_b_sel}, 32'd0);
    tick();
    set_prod(0, 32'd0, 1'b0); set_prod(1, lw_x9, 1'b1);
    @(negedge clk);
    chk("lu_next_stall", {31'd0, if1.stall}, 32'd0);
    chk("lu_next_fwd_b", {30'd0, if1.fwd_b_sel}, 32'd2);
    chk("lu_next_fwd_a", {30'd0, if1.fwd_a_sel}, 32'd0);

    // No hazard: rd=x0, invalid producer, bubble in DEC.
    do_reset();
    dec_ir = add_x6_x0; set_prod(0, addi_x0, 1'b1);
    @(negedge clk);
    chk("x0_stall", {31'd0, if0.stall}, 32'd0);
    chk("x0_fwd_a", {30'd0, if1.fwd_a_sel}, 32'd0);
    chk("x0_fwd_b", {30'd0, if1.fwd_b_sel}, 32'd0);
    tick();
    dec_ir = sub_x8; set_prod(0, add_x7, 1'b0);
    @(negedge clk);
    chk("novld_stall", {31'd0, if0.stall}, 32'd0);
    chk("novld_fwd_a", {30'd0, if1.fwd_a_sel}, 32'd0);
    tick();
    dec_ir = 32'h0003_8000; set_prod(0, add_x7, 1'b1);
    @(negedge clk);
    chk("bubble_stall", {31'd0, if0.stall}, 32'd0);
    chk("bubble_fwd_a", {30'd0, if1.fwd_a_sel}, 32'd0);

    // Flush in the second stall cycle overrides the stall and returns to IDLE.
    do_reset();
    dec_ir = add_x6; set_prod(0, addi_x5, 1'b1);
    @(negedge clk);
    chk("fl_c1_stall", {31'd0, if0.stall}, 32'd1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_stall", {31'd0, if0.stall}, 32'd0);
    chk("fl_pc_write", {31'd0, if0.pc_write}, 32'd1);
    chk("fl_dec_en", {31'd0, if0.dec_en}, 32'd1);
    chk("fl_ex_clear", {31'd0, if0.ex_clear}, 32'd1);
    tick();
    flush = 1'b0; prod_ir = '0; prod_vld = '0;
    @(negedge clk);
    chk("fl_after_stall", {31'd0, if0.stall}, 32'd0);
    chk("fl_after_ex_clear", {31'd0, if0.ex_clear}, 32'd0);

    // Reset mid-stall aborts it and clears the statistics.
    do_reset();
    dec_ir = add_x6; set_prod(0, addi_x5, 1'b1);
    @(negedge clk);
    chk("rs_c1_stall", {31'd0, if0.stall}, 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rs_hold_stall", {31'd0, if0.stall}, 32'd0);
    chk("rs_hold_pc_write", {31'd0, if0.pc_write}, 32'd1);
    chk("rs_hold_ex_clear", {31'd0, if0.ex_clear}, 32'd0);
    chk("rs_hold_fwd_a", {30'd0, if1.fwd_a_sel}, 32'd0);
    tick();
    rst = 1'b0; prod_ir = '0; prod_vld = '0;
    @(negedge clk);
    chk("rs_after_stall", {31'd0, if0.stall}, 32'd0);
    chk("rs_after_dec_en", {31'd0, if0.dec_en}, 32'd1);
`ifdef HAZARD_STATS_EN
    chk("rs_stall_cycles", {16'd0, sc0}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised data-hazard controller for the pipelined OTTER core. It compares the decode-stage instruction's source registers against the destinations of up to three downstream producer stages (EX, MEM, WB). It then either generates forwarding selects or inserts a counted multi-cycle stall. It sits between the IF/DEC pipeline registers, the PC and the DEC/EX register, and drives their enables and clears.

Parameters:
NUM_PROD 3 — number of producer stages compared; legal values 1..3; index 0=EX, 1=MEM, 2=WB.
FWD_EN 1 — 1: forwarding mode, stall only on load-use; 0: stall-only mode, no forwarding.
STAT_W 16 — width of the stall statistics counter (used only when HAZARD_STATS_EN is defined).

Ports:
clk  in  1  core clock; single clock domain.
rst  in  1  synchronous, active-high reset.
dec_ir  in  32  instruction in the DEC stage.
prod_ir  in  32*NUM_PROD  producer instructions, packed, index 0 = EX.
prod_vld  in  NUM_PROD  producer stage holds a real instruction (not a bubble).
flush  in  1  taken branch/jump; squashes DEC.
pc_write  out  1  PC update enable.
dec_en  out  1  IF/DEC register enable.
ex_clear  out  1  insert a bubble into DEC/EX.
fwd_a_sel  out  2  rs1 source: 00=regfile, 01=EX, 10=MEM, 11=WB.
fwd_b_sel  out  2  rs2 source; same encoding as fwd_a_sel.
stall  out  1  stall asserted this cycle.
stall_cycles  out  STAT_W  present only with HAZARD_STATS_EN.

Behaviour:
- Writes rd: producer opcode is not BRANCH or STORE, rd != x0, and prod_vld = 1.
- Uses rs1: decode opcode is not LUI, AUIPC or JAL.
- Uses rs2: decode opcode is BRANCH, STORE or OP.
- Opcode 0 in DEC (bubble) never causes a hazard.
- match[i]: stage i writes rd, and rd equals a used source register of the DEC instruction.
- FWD_EN=1:
  - For each operand, the select is the youngest matching stage (EX > MEM > WB), else 00.
  - Load-use: EX is a LOAD and matches; need = 1; the EX forward for that operand is suppressed.
- FWD_EN=0:
  - Selects are always 00.
  - need = max over matching i of (NUM_PROD - i); e.g. with NUM_PROD=3, an EX match gives 3 and a WB match gives 1.
- FSM states IDLE and STALL; 2-bit down-counter cnt.
- IDLE, need > 0:
  - stall=1 combinationally in the same cycle.
  - If need > 1: cnt <= need-1, go to STALL.
  - If need == 1: stay in IDLE; the hazard is re-evaluated next cycle.
- STALL:
  - stall=1 and hazard detection is masked.
  - cnt decrements each cycle; when cnt==1, go to IDLE on the next edge.
- Stall outputs: pc_write=0, dec_en=0, ex_clear=1.
- Idle outputs: pc_write=1, dec_en=1, ex_clear=0.
- flush has priority over stall:
  - Outputs pc_write=1, dec_en=1, ex_clear=1, stall=0.
  - FSM goes to IDLE and cnt <= 0 on the next edge.
  - This applies in every state.
- rst (synchronous):
  - Next edge: state IDLE, cnt=0.
  - While rst is high, outputs are forced to pc_write=1, dec_en=1, ex_clear=0, fwd selects 00, stall=0.
  - Reset asserted mid-stall aborts the stall.
- Stage-index edge case: with NUM_PROD < 3, the absent stages never match.

Optional Feature:
HAZARD_STATS_EN
- Defined: stall_cycles increments on each cycle with stall=1, saturates at all-ones, and clears on rst.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package otter_pipe_pkg:
  - opcode_t enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM).
  - fwd_sel_t enum (REGF, FEX, FMEM, FWB).
  - Functions writes_rd, uses_rs1, uses_rs2.
- Sub-module hazard_match: one instance per producer stage; outputs the match bits for rs1/rs2 and an is_load flag.

Test Plan:
1. FWD_EN=0, NUM_PROD=3: EX=addi x5,x0,1, then DEC=add x6,x5,x5 -> stall high 3 cycles (pc_write=0, ex_clear=1), then released; stall_cycles=3.
2. FWD_EN=1: EX=add x7,x1,x2, DEC=sub x8,x7,x3 -> fwd_a_sel=01, fwd_b_sel=00, no stall.
3. FWD_EN=1: EX=lw x9,0(x1), DEC=sw x9,4(x2) -> 1-cycle stall; next cycle (lw in MEM) fwd_b_sel=10, stall=0.
4. Producer rd=x0, or prod_vld=0 with a matching rd -> no stall, selects 00.
5. FWD_EN=0: flush asserted in the 2nd stall cycle -> same cycle pc_write=1, ex_clear=1, stall=0; next cycle FSM in IDLE.
6. rst asserted mid-stall -> next cycle all outputs at reset values; stall_cycles=0.
